source_ram_bank_ctrl: RTL

- Parametrised successor to the fixed 4 x 128-bit source RAM bank array.
- Holds N_BANKS raw data packets, one packet per bank, each bank an inferred DEPTH x DATA_W synchronous RAM.
- Adds a per-bank fill/drain state machine, packet length tracking, write backpressure, and a framed read stream with valid/last.
- Sits between the packet ingest logic (writer) and the encoder datapath (reader).

---
 rtl/source_ram_pkg.sv | 21 ++
 rtl/source_ram_bank.sv | 30 +++
 rtl/source_ram_bank_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/source_ram_pkg.sv
// Shared types and default sizing for the source RAM bank controller.
package source_ram_pkg;

  // Per-bank life cycle: a bank fills with one packet, holds it, then drains it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } bank_state_t;

  localparam int SRC_DATA_W  = 128;
  localparam int SRC_DEPTH   = 256;
  localparam int SRC_N_BANKS = 4;

  // A bank takes write beats only before its packet is complete.
  function automatic logic is_writable(input bank_state_t st);
    return (st == ST_EMPTY) || (st == ST_FILL);
  endfunction

endpackage

// File: rtl/source_ram_bank.sv
// Single-port synchronous RAM for one packet bank; read data is registered
// (one cycle of latency). Write and read are never requested together.
module source_ram_bank
  import source_ram_pkg::*;
#(
  parameter int DATA_W = SRC_DATA_W,
  parameter int DEPTH  = SRC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write and registered read through the one shared address port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/source_ram_bank_ctrl.sv
// N-bank packet buffer: each bank is filled with one packet by the ingest
// side, then drained as a framed valid/last stream to the encoder side.
module source_ram_bank_ctrl
  import source_ram_pkg::*;
#(
  parameter int N_BANKS = SRC_N_BANKS,
  parameter int DATA_W  = SRC_DATA_W,
  parameter int DEPTH   = SRC_DEPTH,
  localparam int BANK_W = $clog2(N_BANKS),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               ram_clk,
  input  logic               rst,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_last,
  input  logic               rd_req,
  input  logic [BANK_W-1:0]  rd_bank,
  output logic               rd_busy,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  output logic [N_BANKS-1:0] bank_full,
  output logic [N_BANKS-1:0] bank_empty,
  output logic               err_ovf,
  output logic               err_rd
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t       state_r    [N_BANKS];
  bank_state_t       state_nxt  [N_BANKS];
  logic [ADDR_W-1:0] wr_ptr_r   [N_BANKS];
  logic [ADDR_W-1:0] wr_ptr_nxt [N_BANKS];
  logic [LEN_W-1:0]  len_r      [N_BANKS];
  logic [LEN_W-1:0]  len_nxt    [N_BANKS];
  logic [DATA_W-1:0] ram_rdata  [N_BANKS];

  logic              rd_busy_r;
  logic              issue_r;
  logic              rd_valid_r;
  logic              rd_last_r;
  logic              err_ovf_r;
  logic              err_rd_r;
  logic [BANK_W-1:0] rd_sel_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [N_BANKS-1:0] bank_full_r;
  logic [N_BANKS-1:0] bank_empty_r;

  logic wr_ready_s;
  logic wr_accept_s;
  logic wr_end_s;
  logic wr_trunc_s;
  logic rd_accept_s;
  logic issue_end_s;

  assign wr_ready_s  = is_writable(state_r[wr_bank]);
  assign wr_accept_s = wr_valid && wr_ready_s;
  // A packet closes on wr_last or when the bank's last word is written.
  assign wr_end_s    = wr_last || (wr_ptr_r[wr_bank] == LAST_ADDR);
  assign wr_trunc_s  = wr_accept_s && !wr_last && (wr_ptr_r[wr_bank] == LAST_ADDR);
  // Requests see the pre-edge state, so a bank completing this edge is still FILL.
  assign rd_accept_s = rd_req && !rd_busy_r && (state_r[rd_bank] == ST_FULL);
  assign issue_end_s = issue_r && ({1'b0, rd_addr_r} == (len_r[rd_sel_r] - LEN_W'(1)));

  // Next bank state, write pointer and packet length for every bank.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      state_nxt[b]  = state_r[b];
      wr_ptr_nxt[b] = wr_ptr_r[b];
      len_nxt[b]    = len_r[b];
    end
    for (int b = 0; b < N_BANKS; b++) begin
      if (wr_accept_s && (wr_bank == BANK_W'(b))) begin
        if (wr_end_s) begin
          state_nxt[b]  = ST_FULL;
          len_nxt[b]    = {1'b0, wr_ptr_r[b]} + LEN_W'(1);
          wr_ptr_nxt[b] = '0;
        end else begin
          state_nxt[b]  = ST_FILL;
          wr_ptr_nxt[b] = wr_ptr_r[b] + ADDR_W'(1);
        end
      end else if (rd_accept_s && (rd_bank == BANK_W'(b))) begin
        state_nxt[b] = ST_DRAIN;
      end else if (rd_last_r && (rd_sel_r == BANK_W'(b))) begin
        state_nxt[b] = ST_EMPTY;
      end else begin
        state_nxt[b] = state_r[b];
      end
    end
  end

  // Bank state registers and the registered full/empty status vectors.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      for (int b = 0; b < N_BANKS; b++) begin
        state_r[b]  <= ST_EMPTY;
        wr_ptr_r[b] <= '0;
        len_r[b]    <= '0;
      end
      bank_full_r  <= '0;
      bank_empty_r <= '1;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        state_r[b]      <= state_nxt[b];
        wr_ptr_r[b]     <= wr_ptr_nxt[b];
        len_r[b]        <= len_nxt[b];
        bank_full_r[b]  <= (state_nxt[b] == ST_FULL);
        bank_empty_r[b] <= (state_nxt[b] == ST_EMPTY);
      end
    end
  end

  // Drain sequencer: issue addresses 0..len-1, then frame the RAM output.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      rd_busy_r  <= 1'b0;
      issue_r    <= 1'b0;
      rd_sel_r   <= '0;
      rd_addr_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      if (rd_accept_s) begin
        rd_busy_r <= 1'b1;
        issue_r   <= 1'b1;
        rd_sel_r  <= rd_bank;
        rd_addr_r <= '0;
      end else if (issue_r) begin
        if (issue_end_s) begin
          issue_r <= 1'b0;
        end else begin
          rd_addr_r <= rd_addr_r + ADDR_W'(1);
        end
      end else if (rd_last_r) begin
        rd_busy_r <= 1'b0;
      end
      rd_valid_r <= issue_r;
      rd_last_r  <= issue_end_s;
    end
  end

  // Sticky error flags for truncated packets and rejected drain requests.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      err_ovf_r <= 1'b0;
      err_rd_r  <= 1'b0;
    end else begin
      err_ovf_r <= err_ovf_r || wr_trunc_s;
      err_rd_r  <= err_rd_r || (rd_req && !rd_accept_s);
    end
  end

  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    logic              we_s;
    logic              re_s;
    logic [ADDR_W-1:0] addr_s;

    // Filling and draining never overlap within a bank, so one port suffices.
    assign we_s   = wr_accept_s && (wr_bank == BANK_W'(g));
    assign re_s   = issue_r && (rd_sel_r == BANK_W'(g));
    assign addr_s = we_s ? wr_ptr_r[g] : rd_addr_r;

    source_ram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk   (ram_clk),
      .we    (we_s),
      .re    (re_s),
      .addr  (addr_s),
      .wdata (wr_data),
      .rdata (ram_rdata[g])
    );
  end

  assign wr_ready   = wr_ready_s;
  assign rd_busy    = rd_busy_r;
  assign rd_valid   = rd_valid_r;
  assign rd_last    = rd_last_r;
  // Gate the RAM output so rd_data is zero whenever no word is presented.
  assign rd_data    = rd_valid_r ? ram_rdata[rd_sel_r] : '0;
  assign bank_full  = bank_full_r;
  assign bank_empty = bank_empty_r;
  assign err_ovf    = err_ovf_r;
  assign err_rd     = err_rd_r;

endmodule
